// File: rtl/fdiv_pkg.sv
// Shared definitions for the clock divider and the frequency meter:
// nominal periods for each divisor code, the code type and the meter FSM states.
package fdiv_pkg;

    localparam int unsigned NOM0_DEF = 512000;
    localparam int unsigned NOM1_DEF = 1024000;
    localparam int unsigned NOM2_DEF = 2048000;
    localparam int unsigned NOM3_DEF = 4096000;

    typedef logic [1:0] code_t;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus rising-edge detect.
// With FMEAS_DUTY_EN the synchronized level is also exported for duty measurement.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
`ifdef FMEAS_DUTY_EN
    ,
    output logic level
`endif
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain followed by the edge-history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

`ifdef FMEAS_DUTY_EN
    assign level = s2;
`endif

endmodule

// File: rtl/f_meas.sv
// Period meter: counts fin cycles between rising edges of sig_in and decodes
// the period back to a 2-bit divisor code. Optional duty measurement is
// enabled with the FMEAS_DUTY_EN macro; otherwise high_time is tied to 0.
module f_meas
    import fdiv_pkg::*;
#(
    parameter int unsigned      CNT_W     = 32,
    parameter logic [CNT_W-1:0] NOM0      = CNT_W'(NOM0_DEF),
    parameter logic [CNT_W-1:0] NOM1      = CNT_W'(NOM1_DEF),
    parameter logic [CNT_W-1:0] NOM2      = CNT_W'(NOM2_DEF),
    parameter logic [CNT_W-1:0] NOM3      = CNT_W'(NOM3_DEF),
    parameter int unsigned      TOL_SHIFT = 4,
    parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(8192000)
) (
    input  logic             fin,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       code,
    output logic             code_ok,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] high_time
);

    state_t           state;
    state_t           state_nxt;
    logic             rise;
    logic             arm;
    logic             load;
    logic             expire;
    logic [CNT_W-1:0] cnt;
    code_t            dec_code;
    logic             dec_ok;

    // Tolerance test: absolute difference taken as larger minus smaller, no sign bit needed.
    function automatic logic in_band(input logic [CNT_W-1:0] val, input logic [CNT_W-1:0] nom);
        logic [CNT_W-1:0] diff;
        diff = (val >= nom) ? (val - nom) : (nom - val);
        return diff <= (nom >> TOL_SHIFT);
    endfunction

`ifdef FMEAS_DUTY_EN
    logic             level;
    logic [CNT_W-1:0] hcnt;

    sync_edge u_sync (
        .clk   (fin),
        .rst   (rst),
        .sig   (sig_in),
        .rise  (rise),
        .level (level)
    );
`else
    sync_edge u_sync (
        .clk  (fin),
        .rst  (rst),
        .sig  (sig_in),
        .rise (rise)
    );
`endif

    // FSM state register.
    always_ff @(posedge fin) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and control strobes; a rise wins over an expiring count.
    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        load      = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    arm       = 1'b1;
                    state_nxt = MEAS;
                end
            end
            MEAS: begin
                if (rise) begin
                    load = 1'b1;
                end else if (cnt == TIMEOUT) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Lowest matching nominal wins; on no match the current code is kept.
    always_comb begin
        dec_ok   = 1'b1;
        dec_code = code;
        if (in_band(cnt, NOM0))      dec_code = 2'd0;
        else if (in_band(cnt, NOM1)) dec_code = 2'd1;
        else if (in_band(cnt, NOM2)) dec_code = 2'd2;
        else if (in_band(cnt, NOM3)) dec_code = 2'd3;
        else                         dec_ok   = 1'b0;
    end

    // Period counter, captured results and lock/timeout flags.
    always_ff @(posedge fin) begin
        if (rst) begin
            cnt     <= '0;
            period  <= '0;
            code    <= '0;
            code_ok <= 1'b0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= load;
            if (arm || load)
                cnt <= CNT_W'(1);
            else if (state == MEAS && !expire)
                cnt <= cnt + CNT_W'(1);
            if (load) begin
                period  <= cnt;
                code    <= dec_code;
                code_ok <= dec_ok;
                timeout <= 1'b0;
            end
            if (expire) begin
                timeout <= 1'b1;
                code_ok <= 1'b0;
            end
        end
    end

`ifdef FMEAS_DUTY_EN
    // High-cycle counter; the rise cycle itself is high, so it restarts at 1.
    always_ff @(posedge fin) begin
        if (rst) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            if (arm || load)
                hcnt <= CNT_W'(1);
            else if (state == MEAS && level && hcnt != TIMEOUT)
                hcnt <= hcnt + CNT_W'(1);
            if (load)
                high_time <= hcnt;
        end
    end
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_f_meas.sv
// Directed bench for f_meas with small nominal periods (2,4,8,16) and TIMEOUT=64.
// Expected measurements are queued when a rising edge is driven and checked
// when the DUT pulses valid.
module tb_f_meas;

    logic        fin = 1'b0;
    logic        rst;
    logic        sig_in;
    logic [31:0] period;
    logic [1:0]  code;
    logic        code_ok;
    logic        valid;
    logic        timeout;
    logic [31:0] high_time;

    int n_assert = 0;
    int n_fail   = 0;
    int prev_hi  = 0;
    int prev_lo  = 0;

    typedef struct {
        logic [31:0] per;
        logic [1:0]  cd;
        logic        ok;
        logic        tmo;
        logic [31:0] hi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    f_meas #(
        .CNT_W     (32),
        .NOM0      (32'd2),
        .NOM1      (32'd4),
        .NOM2      (32'd8),
        .NOM3      (32'd16),
        .TOL_SHIFT (4),
        .TIMEOUT   (32'd64)
    ) dut (
        .fin       (fin),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .code      (code),
        .code_ok   (code_ok),
        .valid     (valid),
        .timeout   (timeout),
        .high_time (high_time)
    );

    always #5 fin = ~fin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, period, 32'd0);
        check({tag, "_flags"}, {27'd0, code, code_ok, valid, timeout}, 32'd0);
        check({tag, "_high"}, high_time, 32'd0);
    endtask

    function automatic logic [31:0] duty_exp(input int hi);
`ifdef FMEAS_DUTY_EN
        return 32'(hi);
`else
        return (hi > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic push(input int per, input logic [1:0] cd, input logic ok, input int hi);
        exp_t e;
        e.per = 32'(per);
        e.cd  = cd;
        e.ok  = ok;
        e.tmo = 1'b0;
        e.hi  = duty_exp(hi);
        sb.push_back(e);
    endtask

    // One sig_in pulse; its leading edge measures the previous pulse.
    task automatic pulse(input int hi, input int lo, input bit expv,
                         input logic [1:0] cd, input logic ok);
        if (expv) push(prev_hi + prev_lo, cd, ok, prev_hi);
        sig_in = 1'b1;
        repeat (hi) @(negedge fin);
        sig_in = 1'b0;
        repeat (lo) @(negedge fin);
        prev_hi = hi;
        prev_lo = lo;
    endtask

    // Scoreboard consumer: every valid must match the oldest queued expectation.
    always @(negedge fin) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("valid_expected", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("period", period, mon_e.per);
                check("code", {30'd0, code}, {30'd0, mon_e.cd});
                check("code_ok", {31'd0, code_ok}, {31'd0, mon_e.ok});
                check("timeout_at_valid", {31'd0, timeout}, {31'd0, mon_e.tmo});
                check("high_time", high_time, mon_e.hi);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;

        // Reset held while sig_in toggles: everything stays 0.
        for (int i = 0; i < 24; i++) begin
            sig_in = ((i % 8) < 4);
            @(negedge fin);
            check_zero("reset_hold");
        end
        sig_in = 1'b0;
        rst    = 1'b0;
        repeat (3) @(negedge fin);

        // Period 8, 4 high: first rise only arms.
        pulse(4, 4, 0, 2'b00, 1'b0);
        pulse(4, 4, 1, 2'b10, 1'b1);
        pulse(4, 4, 1, 2'b10, 1'b1);
        pulse(4, 4, 1, 2'b10, 1'b1);

        // Period 16, then period 4.
        pulse(8, 8, 1, 2'b10, 1'b1);
        pulse(8, 8, 1, 2'b11, 1'b1);
        pulse(2, 2, 1, 2'b11, 1'b1);
        pulse(2, 2, 1, 2'b01, 1'b1);
        pulse(2, 2, 1, 2'b01, 1'b1);

        // Tolerance edge of NOM3 (band 15..17): 17 matches, 18 does not.
        pulse(9, 8, 1, 2'b01, 1'b1);
        pulse(9, 9, 1, 2'b11, 1'b1);
        pulse(4, 4, 1, 2'b11, 1'b0);

        // Lock at 8, then period 12: no match, code holds.
        pulse(4, 4, 1, 2'b10, 1'b1);
        pulse(6, 6, 1, 2'b10, 1'b1);
        pulse(6, 6, 1, 2'b10, 1'b0);
        pulse(4, 4, 1, 2'b10, 1'b0);

        // Last rise, then hold low until the timeout fires 64 cycles later.
        push(prev_hi + prev_lo, 2'b10, 1'b1, prev_hi);
        sig_in = 1'b1;
        repeat (4) @(negedge fin);
        sig_in = 1'b0;
        repeat (62) @(negedge fin);
        check("timeout_before", {31'd0, timeout}, 32'd0);
        check("code_ok_before", {31'd0, code_ok}, 32'd1);
        @(negedge fin);
        check("timeout_set", {31'd0, timeout}, 32'd1);
        check("code_ok_dropped", {31'd0, code_ok}, 32'd0);
        check("period_held", period, 32'd8);
        check("code_held", {30'd0, code}, 32'd2);
        repeat (5) @(negedge fin);
        check("timeout_sticky", {31'd0, timeout}, 32'd1);

        // Relock at period 2 after timeout.
        pulse(1, 1, 0, 2'b00, 1'b0);
        pulse(1, 1, 1, 2'b00, 1'b1);
        pulse(4, 4, 1, 2'b00, 1'b1);

        // Reset mid-period during the low phase.
        push(prev_hi + prev_lo, 2'b10, 1'b1, prev_hi);
        sig_in = 1'b1;
        repeat (4) @(negedge fin);
        sig_in = 1'b0;
        repeat (2) @(negedge fin);
        rst = 1'b1;
        @(negedge fin);
        check_zero("reset_mid");
        rst = 1'b0;
        pulse(4, 4, 0, 2'b00, 1'b0);
        pulse(4, 4, 1, 2'b10, 1'b1);
        pulse(4, 4, 1, 2'b10, 1'b1);

        // Drain outstanding expectations with a bounded wait.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge fin);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
